// File: rtl/gate_drive_p16.sv
// Gate-drive output stage: complementary high/low-side gate words from a 16-sample square wave,
// burst-gated by enable, with fault latch. Define GATE_DRIVE_DEADTIME_EN to enable dead-time insertion.
module gate_drive_p16 #(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int INITIAL_DEAD  = 2
) (
  input  logic        p_clock,
  input  logic        reset_n,
  input  logic [15:0] sig_in,
  input  logic        enable,
  input  logic [3:0]  dead_time,
  input  logic        fault,
  input  logic        fault_clear,
  output logic [15:0] hs_out,
  output logic [15:0] ls_out,
  output logic        running,
  output logic        faulted,
  output logic        timeout_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_DRAINING = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [7:0] LAST_DRAIN = 8'(DRAIN_TIMEOUT - 1);

  state_t      state_r, state_s, drain_state_s;
  logic [15:0] prev_r;
  logic [7:0]  cnt_r, cnt_s, drain_cnt_s;
  logic [15:0] prior_s, rise_s, fall_s, from_rise_s, before_fall_s;
  logic        rise_acc_s, fall_acc_s;
  logic [15:0] act_s, drain_act_s, delayed_s, hs_s, ls_s;
  logic        timeout_s, drain_to_s;

  // s[i-1] for every sample of the current word, reaching back into the previous word for bit 0.
  assign prior_s = {sig_in[14:0], prev_r[15]};
  assign rise_s  = sig_in & ~prior_s;
  assign fall_s  = ~sig_in & prior_s;

`ifdef GATE_DRIVE_DEADTIME_EN
  logic [3:0] dead_r;

  // Dead time is only sampled while idle so it never changes inside a burst.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      dead_r <= 4'(INITIAL_DEAD);
    end else if (state_r == ST_IDLE) begin
      dead_r <= dead_time;
    end else begin
      dead_r <= dead_r;
    end
  end

  assign delayed_s = 16'({sig_in, prev_r} >> (5'd16 - {1'b0, dead_r}));
`else
  logic unused_dead_s;
  assign unused_dead_s = ^dead_time;
  assign delayed_s     = sig_in;
`endif

  // Prefix masks: samples from the first rising edge on, and samples before the first falling edge.
  always_comb begin
    rise_acc_s    = 1'b0;
    fall_acc_s    = 1'b0;
    from_rise_s   = 16'h0000;
    before_fall_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      rise_acc_s       = rise_acc_s | rise_s[i];
      fall_acc_s       = fall_acc_s | fall_s[i];
      from_rise_s[i]   = rise_acc_s;
      before_fall_s[i] = ~fall_acc_s;
    end
  end

  // Drain evaluation, shared by DRAINING and the RUNNING word on which enable drops.
  always_comb begin
    drain_state_s = ST_DRAINING;
    drain_act_s   = 16'hFFFF;
    drain_cnt_s   = cnt_r + 8'd1;
    drain_to_s    = 1'b0;
    if (|fall_s) begin
      drain_state_s = ST_IDLE;
      drain_act_s   = before_fall_s;
      drain_cnt_s   = 8'd0;
    end else if (cnt_r == LAST_DRAIN) begin
      drain_state_s = ST_IDLE;
      drain_act_s   = 16'h0000;
      drain_cnt_s   = 8'd0;
      drain_to_s    = 1'b1;
    end else begin
      drain_state_s = ST_DRAINING;
    end
  end

  // Next-state and active-mask selection; fault overrides every state.
  always_comb begin
    state_s   = state_r;
    cnt_s     = 8'd0;
    act_s     = 16'h0000;
    timeout_s = 1'b0;
    if (fault) begin
      state_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) state_s = ST_ARMED;
          else        state_s = ST_IDLE;
        end
        ST_ARMED: begin
          if (!enable) begin
            state_s = ST_IDLE;
          end else if (|rise_s) begin
            state_s = ST_RUNNING;
            act_s   = from_rise_s;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_RUNNING: begin
          if (enable) begin
            state_s = ST_RUNNING;
            act_s   = 16'hFFFF;
          end else begin
            state_s   = drain_state_s;
            act_s     = drain_act_s;
            cnt_s     = drain_cnt_s;
            timeout_s = drain_to_s;
          end
        end
        ST_DRAINING: begin
          state_s   = drain_state_s;
          act_s     = drain_act_s;
          cnt_s     = drain_cnt_s;
          timeout_s = drain_to_s;
        end
        ST_FAULT: begin
          if (fault_clear) state_s = ST_IDLE;
          else             state_s = ST_FAULT;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Both sides require the current and the delayed sample to agree, so they can never overlap.
  assign hs_s = act_s & sig_in & delayed_s;
  assign ls_s = act_s & ~sig_in & ~delayed_s;

  // State, history and registered outputs.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 8'd0;
      prev_r        <= 16'h0000;
      hs_out        <= 16'h0000;
      ls_out        <= 16'h0000;
      running       <= 1'b0;
      faulted       <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      prev_r        <= sig_in;
      hs_out        <= hs_s;
      ls_out        <= ls_s;
      running       <= (state_s == ST_RUNNING) || (state_s == ST_DRAINING);
      faulted       <= (state_s == ST_FAULT);
      timeout_pulse <= timeout_s;
    end
  end

endmodule

// File: tb/tb_gate_drive_p16.sv
// Scoreboard bench for gate_drive_p16: directed words push expected results, a monitor compares them.
module tb_gate_drive_p16;

  logic        p_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sig_in = 16'h0000;
  logic        enable = 1'b0;
  logic [3:0]  dead_time = 4'd0;
  logic        fault = 1'b0;
  logic        fault_clear = 1'b0;
  logic [15:0] hs_out, ls_out;
  logic        running, faulted, timeout_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] hs;
    logic [15:0] ls;
    logic        run;
    logic        flt;
    logic        to;
    bit          chk;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

`ifdef GATE_DRIVE_DEADTIME_EN
  localparam logic [15:0] D3_A_HS = 16'hF800, D3_A_LS = 16'h0000;
  localparam logic [15:0] D3_B_HS = 16'h00FF, D3_B_LS = 16'hF800;
  localparam logic [15:0] D3_C_HS = 16'h0000, D3_C_LS = 16'hFFFF;
  localparam logic [15:0] D3_D_HS = 16'hFFF8, D3_D_LS = 16'h0000;
`else
  localparam logic [15:0] D3_A_HS = 16'hFF00, D3_A_LS = 16'h0000;
  localparam logic [15:0] D3_B_HS = 16'h00FF, D3_B_LS = 16'hFF00;
  localparam logic [15:0] D3_C_HS = 16'h0000, D3_C_LS = 16'hFFFF;
  localparam logic [15:0] D3_D_HS = 16'hFFFF, D3_D_LS = 16'h0000;
`endif

  gate_drive_p16 #(.DRAIN_TIMEOUT(64), .INITIAL_DEAD(2)) dut (
    .p_clock      (p_clock),
    .reset_n      (reset_n),
    .sig_in       (sig_in),
    .enable       (enable),
    .dead_time    (dead_time),
    .fault        (fault),
    .fault_clear  (fault_clear),
    .hs_out       (hs_out),
    .ls_out       (ls_out),
    .running      (running),
    .faulted      (faulted),
    .timeout_pulse(timeout_pulse)
  );

  always #5 p_clock = ~p_clock;

  task automatic step(input logic [15:0] sig, input logic en, input logic flt, input logic clr,
                      input logic [3:0] dt, input bit chk, input logic [15:0] ehs,
                      input logic [15:0] els, input logic erun, input logic eflt,
                      input logic eto, input string tag);
    exp_t e;
    @(negedge p_clock);
    sig_in      = sig;
    enable      = en;
    fault       = flt;
    fault_clear = clr;
    dead_time   = dt;
    e.hs = ehs; e.ls = els; e.run = erun; e.flt = eflt; e.to = eto; e.chk = chk; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [15:0] ehs, input logic [15:0] els,
                           input logic erun, input logic eflt, input logic eto);
    checks++;
    if (hs_out !== ehs || ls_out !== els || running !== erun || faulted !== eflt ||
        timeout_pulse !== eto) begin
      errors++;
      $display("FAIL %s: got hs=%h ls=%h run=%b flt=%b to=%b, want hs=%h ls=%h run=%b flt=%b to=%b",
               tag, hs_out, ls_out, running, faulted, timeout_pulse, ehs, els, erun, eflt, eto);
    end
  endtask

  // Monitor: one output word per clock; pop the matching expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge p_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ((hs_out & ls_out) !== 16'h0000) begin
          errors++;
          $display("FAIL overlap(%s): hs=%h ls=%h, want no common bit", e.tag, hs_out, ls_out);
        end
        if (e.chk) begin
          checks++;
          if (hs_out !== e.hs || ls_out !== e.ls || running !== e.run || faulted !== e.flt ||
              timeout_pulse !== e.to) begin
            errors++;
            $display("FAIL %s: got hs=%h ls=%h run=%b flt=%b to=%b, want hs=%h ls=%h run=%b flt=%b to=%b",
                     e.tag, hs_out, ls_out, running, faulted, timeout_pulse,
                     e.hs, e.ls, e.run, e.flt, e.to);
          end
        end
      end
    end
  end

  initial begin
    #12;
    check_now("reset_state", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Burst start on 0x0000/0xFFFF toggling, D=0.
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "idle_to_armed");
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "armed_no_edge");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "first_rise");
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, "run_low_word");
    step(16'hFF00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'hFF00, 16'h00FF, 1'b1, 1'b0, 1'b0, "run_half_word");
    // Enable drops on 0x00FF after 0xFF00: mask ends at the falling edge at bit 8.
    step(16'h00FF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b0, "drop_on_fall");
    step(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "idle_after_drain");

    // Mid-word rising edge in ARMED, then drain timeout with sig held high.
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "rearm");
    step(16'h0F00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0F00, 16'hF000, 1'b1, 1'b0, 1'b0, "armed_mid_rise");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "run_high");
    for (int k = 1; k <= 63; k++) begin
      step(16'hFFFF, (k >= 30 && k <= 35), 1'b0, 1'b0, 4'd0, 1'b1,
           16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "drain_hold");
    end
    step(16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, "drain_timeout");
    step(16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "post_timeout");

    // Dead time 3 requested (honoured only when dead-time insertion is built).
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "dt_arm");
    step(16'hFF00, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, D3_A_HS, D3_A_LS, 1'b1, 1'b0, 1'b0, "dt_rise8");
    step(16'h00FF, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, D3_B_HS, D3_B_LS, 1'b1, 1'b0, 1'b0, "dt_run");
    step(16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, D3_C_HS, D3_C_LS, 1'b1, 1'b0, 1'b0, "dt_drain_low");
    step(16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, D3_D_HS, D3_D_LS, 1'b1, 1'b0, 1'b0, "dt_drain_high");
    step(16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "dt_drain_fall0");

    // Fault latch and clear handshake.
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "f_arm");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "f_run");
    step(16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, "fault_hit");
    step(16'hFFFF, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, "clear_while_fault");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, "fault_hold");
    step(16'h0000, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "fault_cleared");
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "f_rearm");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "f_rerun");

    // Asynchronous reset mid-burst, then the burst must wait for a fresh rising edge.
    @(negedge p_clock);
    #2;
    reset_n = 1'b0;
    sig_in = 16'h0000; enable = 1'b0; fault = 1'b0; fault_clear = 1'b0;
    #1;
    check_now("async_reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "rst_idle_high");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "rst_no_fresh_edge");
    step(16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "rst_low");
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "rst_fresh_rise");

    // Random words: only the no-overlap property is checked.
    for (int n = 0; n < 3000; n++) begin
      step(16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'b0,
           16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "random");
    end

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge p_clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
